// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the registered immediate generator.
// Optional CSR-immediate (fmt Z) decoding is enabled with IMM_GEN_ZICSR_EN.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_t;

  // Encoding is {main_valid, skid_valid}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_t;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decoder: instr -> XLEN immediate, format, illegal flag.
// IMM_GEN_ZICSR_EN adds zero-extended CSR immediates (fmt Z) for SYSTEM with funct3[2]=1.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OP_IMM, LOAD, JALR: begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
          fmt   = FMT_I;
        end
        STORE: begin
          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          fmt   = FMT_S;
        end
        BRANCH: begin
          imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          fmt   = FMT_B;
        end
        LUI, AUIPC: begin
          imm32 = {instr[31:12], 12'b0};
          fmt   = FMT_U;
        end
        JAL: begin
          imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          fmt   = FMT_J;
        end
        OP, MISC_MEM: ;
`ifdef IMM_GEN_ZICSR_EN
        SYSTEM: begin
          if (instr[14]) begin
            imm32 = {27'b0, instr[19:15]};
            fmt   = FMT_Z;
          end
        end
`else
        SYSTEM: illegal = 1'b1;
`endif
        default: illegal = 1'b1;
      endcase
    end
  end

  // Signed 32-bit intermediate: the width cast sign-extends for XLEN=64
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and 2-entry skid buffer.
// Optional CSR-immediate decoding is enabled with IMM_GEN_ZICSR_EN (see imm_decode).
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_t         out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_t         dec_fmt;
  logic             dec_illegal;

  logic [XLEN-1:0]  skid_imm;
  imm_fmt_t         skid_fmt;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_illegal;

  skid_state_t state, state_nxt;
  logic accept, retire;
  logic load_main_in, load_main_skid, load_skid;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Handshake flags come straight from the state flops
  assign out_valid = state[1];
  assign in_ready  = ~state[0];
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && retire) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (retire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (retire) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any same-cycle accept or retire
    if (flush) begin
      state_nxt      = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_imm     <= '0;
      out_fmt     <= FMT_NONE;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (load_main_in) begin
      out_imm     <= dec_imm;
      out_fmt     <= dec_fmt;
      out_tag     <= in_tag;
      out_illegal <= dec_illegal;
    end else if (load_main_skid) begin
      out_imm     <= skid_imm;
      out_fmt     <= skid_fmt;
      out_tag     <= skid_tag;
      out_illegal <= skid_illegal;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_tag     <= '0;
      skid_illegal <= 1'b0;
    end else if (load_skid) begin
      skid_imm     <= dec_imm;
      skid_fmt     <= dec_fmt;
      skid_tag     <= in_tag;
      skid_illegal <= dec_illegal;
    end
  end

endmodule
